// File: rtl/byte_dispatch_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : byte_dispatch_seq                                             |
// | Purpose  : holds one byte and drives a 3:8 decoder until the addressed   |
// |            channel accepts it or a stall timeout drops it.               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module byte_dispatch_seq #(
   parameter int DW      = 8,
   parameter int TIMEOUT = 16,
   parameter int CW      = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [DW-1:0] s_data,
   input  logic [2:0]    s_dest,
   input  logic          rr_mode,
   input  logic [7:0]    ch_ready,
   output logic [2:0]    sel,
   output logic [DW-1:0] dout,
   output logic          dis,
   output logic          xfer,
   output logic          drop,
   output logic [CW-1:0] xfer_cnt,
   output logic [CW-1:0] drop_cnt
);

   localparam int c_wait_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_wait_w-1:0] c_wait_max = c_wait_w'(TIMEOUT - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_DRIVE = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [2:0]           r_dest;
   logic [2:0]           r_rr_ptr;
   logic [DW-1:0]        r_data;
   logic [c_wait_w-1:0]  r_wait;
   logic [CW-1:0]        r_xfer_cnt;
   logic [CW-1:0]        r_drop_cnt;

   logic                 w_drive;
   logic                 w_ch_ok;
   logic                 w_xfer;
   logic                 w_drop;
   logic                 w_ready;
   logic                 w_accept;

   // Handshake terms are combinational so a freed slot refills in the same cycle.
   assign w_drive  = (r_state == ST_DRIVE);
   assign w_ch_ok  = ch_ready[r_dest];
   assign w_xfer   = w_drive && w_ch_ok;
   assign w_drop   = w_drive && !w_ch_ok && (r_wait == c_wait_max);
   assign w_ready  = !w_drive || w_xfer || w_drop;
   assign w_accept = s_valid && w_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      sel         = 3'd0;
      dout        = '0;
      dis         = 1'b1;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            sel  = r_dest;
            dout = r_data;
            dis  = 1'b0;
            if (w_accept) begin
               w_state_nxt = ST_DRIVE;
            end else if (w_xfer || w_drop) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dest   <= 3'd0;
         r_data   <= '0;
         r_rr_ptr <= 3'd0;
         r_wait   <= '0;
      end else if (w_accept) begin
         r_data <= s_data;
         r_dest <= rr_mode ? r_rr_ptr : s_dest;
         r_wait <= '0;
         if (rr_mode) begin
            r_rr_ptr <= r_rr_ptr + 3'd1;
         end
      end else if (w_drive && !w_ch_ok && !w_drop) begin
         r_wait <= r_wait + c_wait_w'(1);
      end
   end

   // Counters saturate at all-ones rather than wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_xfer_cnt <= '0;
         r_drop_cnt <= '0;
      end else begin
         if (w_xfer && (r_xfer_cnt != '1)) begin
            r_xfer_cnt <= r_xfer_cnt + CW'(1);
         end
         if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + CW'(1);
         end
      end
   end

   assign s_ready  = w_ready;
   assign xfer     = w_xfer;
   assign drop     = w_drop;
   assign xfer_cnt = r_xfer_cnt;
   assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire
